// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game engine: one-hot state codes and LFSR settings.
package simon_pkg;

    localparam int unsigned STATE_W = 9;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 9'b0_0000_0001,
        ST_GEN      = 9'b0_0000_0010,
        ST_SHOW_ON  = 9'b0_0000_0100,
        ST_SHOW_OFF = 9'b0_0000_1000,
        ST_WAIT_IN  = 9'b0_0001_0000,
        ST_RELEASE  = 9'b0_0010_0000,
        ST_CHECK    = 9'b0_0100_0000,
        ST_LOST     = 9'b0_1000_0000,
        ST_WIN      = 9'b1_0000_0000
    } state_e;

    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1 -> bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic lfsr_feedback(input logic [15:0] v);
        return ^(v & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 16-bit Fibonacci LFSR: loads a seed (zero replaced by the default) and steps on demand.
module simon_lfsr
    import simon_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] value
);

    logic [15:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = (seed == 16'h0000) ? LFSR_SEED_DEFAULT : seed;
        end else if (step) begin
            value_d = {value_q[14:0], lfsr_feedback(value_q)};
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            value_q <= LFSR_SEED_DEFAULT;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/simon_game_engine.sv
// Simon memory game: grows a random colour sequence, plays it back and checks the player's replay.
// Optional input timeout compiled in with macro SIMON_TIMEOUT_EN.
module simon_game_engine
    import simon_pkg::*;
#(
    parameter int unsigned NUM_COLORS     = 4,
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned SHOW_CYCLES    = 50_000_000,
    parameter int unsigned GAP_CYCLES     = 25_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Start,
    input  logic                  On,
    input  logic [15:0]           Seed,
    input  logic [NUM_COLORS-1:0] Btn,
    output logic [NUM_COLORS-1:0] Show_color,
    output logic [6:0]            Level,
    output logic [15:0]           Score,
    output logic [8:0]            State
);

    localparam int unsigned CW      = $clog2(NUM_COLORS);
    localparam int unsigned IW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned CNT_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [15:0] NC16    = 16'(NUM_COLORS);

    if (NUM_COLORS < 2 || NUM_COLORS > 8 || MAX_LEN < 1 || MAX_LEN > 64 ||
        SHOW_CYCLES < 1 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("simon_game_engine: parameter out of legal range");
    end

    state_e                state_q, state_d;
    logic [6:0]            level_q, level_d;
    logic [15:0]           score_q, score_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]         cap_q, cap_d;
    logic [NUM_COLORS-1:0] show_q, show_d;
    logic [NUM_COLORS-1:0] btn_prev_q;

    logic [CW-1:0]         seq_q [MAX_LEN];

    logic                  lfsr_load_c, lfsr_step_c, seq_we_c;
    logic [15:0]           lfsr_val;
    logic [CW-1:0]         gen_col_c, btn_col_c, show_col_c;
    logic [IW-1:0]         wr_addr_c;
    logic                  press_c, last_c, tmo_hit_c;
    logic [16:0]           score_sum_c;

    simon_lfsr u_lfsr (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .load    (lfsr_load_c),
        .seed    (Seed),
        .step    (lfsr_step_c),
        .value   (lfsr_val)
    );

    assign gen_col_c   = CW'(lfsr_val % NC16);
    assign wr_addr_c   = IW'(level_q - 7'd1);
    assign last_c      = (7'(idx_q) == (level_q - 7'd1));
    // A press is a rising edge from all-released; buttons held over a state entry do not count
    assign press_c     = (Btn != '0) && (btn_prev_q == '0);
    assign score_sum_c = {1'b0, score_q} + 17'(level_q);

    always_comb begin
        btn_col_c = '0;
        for (int k = 0; k < NUM_COLORS; k++) begin
            if (Btn[k]) btn_col_c = CW'(k);
        end
    end

`ifdef SIMON_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Counts only while staying in an input-wait state; any entry restarts it
    always_comb begin
        tmo_d = '0;
        if ((state_d == state_q) && ((state_q == ST_WAIT_IN) || (state_q == ST_RELEASE))) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit_c = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        score_d     = score_q;
        idx_d       = idx_q;
        cnt_d       = '0;
        cap_d       = cap_q;
        lfsr_load_c = 1'b0;
        lfsr_step_c = 1'b0;
        seq_we_c    = 1'b0;
        show_col_c  = '0;
        show_d      = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    lfsr_load_c = 1'b1;
                    level_d     = 7'd1;
                    score_d     = 16'h0000;
                    state_d     = ST_GEN;
                end
            end
            ST_GEN: begin
                seq_we_c    = 1'b1;
                lfsr_step_c = 1'b1;
                idx_d       = '0;
                state_d     = ST_SHOW_ON;
            end
            ST_SHOW_ON: begin
                if (cnt_q == CNT_W'(SHOW_CYCLES - 1)) begin
                    state_d = ST_SHOW_OFF;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHOW_OFF: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    if (!last_c) begin
                        idx_d   = idx_q + IW'(1);
                        state_d = ST_SHOW_ON;
                    end else begin
                        idx_d   = '0;
                        state_d = ST_WAIT_IN;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_IN: begin
                if (press_c) begin
                    if ($onehot(Btn)) begin
                        cap_d   = btn_col_c;
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_LOST;
                    end
                end else if (tmo_hit_c) begin
                    state_d = ST_LOST;
                end
            end
            ST_RELEASE: begin
                if (Btn == '0) begin
                    state_d = ST_CHECK;
                end else if (tmo_hit_c) begin
                    state_d = ST_LOST;
                end
            end
            ST_CHECK: begin
                if (cap_q != seq_q[idx_q]) begin
                    state_d = ST_LOST;
                end else if (!last_c) begin
                    idx_d   = idx_q + IW'(1);
                    state_d = ST_WAIT_IN;
                end else begin
                    score_d = score_sum_c[16] ? 16'hFFFF : score_sum_c[15:0];
                    idx_d   = '0;
                    if (level_q == 7'(MAX_LEN)) begin
                        state_d = ST_WIN;
                    end else begin
                        level_d = level_q + 7'd1;
                        state_d = ST_GEN;
                    end
                end
            end
            ST_LOST, ST_WIN: begin
                if (Start) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Switching the game off beats every other transition and side effect
        if (!On) begin
            state_d     = ST_IDLE;
            level_d     = level_q;
            score_d     = score_q;
            idx_d       = '0;
            lfsr_load_c = 1'b0;
            lfsr_step_c = 1'b0;
            seq_we_c    = 1'b0;
        end

        // Registered lamp drive; bypass the entry being written this cycle
        show_col_c = (seq_we_c && (wr_addr_c == idx_d)) ? gen_col_c : seq_q[idx_d];
        if (state_d == ST_SHOW_ON) begin
            for (int k = 0; k < NUM_COLORS; k++) begin
                show_d[k] = (show_col_c == CW'(k));
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            level_q    <= 7'd0;
            score_q    <= 16'h0000;
            idx_q      <= '0;
            cnt_q      <= '0;
            cap_q      <= '0;
            show_q     <= '0;
            btn_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            score_q    <= score_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            cap_q      <= cap_d;
            show_q     <= show_d;
            btn_prev_q <= Btn;
        end
    end

    always_ff @(posedge Clk) begin
        if (seq_we_c) begin
            seq_q[wr_addr_c] <= gen_col_c;
        end
    end

    assign Show_color = show_q;
    assign Level      = level_q;
    assign Score      = score_q;
    assign State      = state_q;

endmodule

// File: tb/tb_simon_game_engine.sv
// Directed self-checking bench for simon_game_engine with short playback timings.
module tb_simon_game_engine;

    localparam logic [8:0] S_IDLE     = 9'h001;
    localparam logic [8:0] S_GEN      = 9'h002;
    localparam logic [8:0] S_SHOW_ON  = 9'h004;
    localparam logic [8:0] S_SHOW_OFF = 9'h008;
    localparam logic [8:0] S_WAIT_IN  = 9'h010;
    localparam logic [8:0] S_RELEASE  = 9'h020;
    localparam logic [8:0] S_LOST     = 9'h080;
    localparam logic [8:0] S_WIN      = 9'h100;

    logic        Clk;
    logic        Reset_n;
    logic        Start;
    logic        On;
    logic [15:0] Seed;
    logic [3:0]  Btn;
    logic [3:0]  Show_color;
    logic [6:0]  Level;
    logic [15:0] Score;
    logic [8:0]  State;

    int checks = 0;
    int errors = 0;
    int exp_seq [4];

    simon_game_engine #(
        .NUM_COLORS     (4),
        .MAX_LEN        (4),
        .SHOW_CYCLES    (4),
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Start      (Start),
        .On         (On),
        .Seed       (Seed),
        .Btn        (Btn),
        .Show_color (Show_color),
        .Level      (Level),
        .Score      (Score),
        .State      (State)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [3:0] oh(input int c);
        logic [3:0] v;
        v = 4'b0001 << c;
        return v;
    endfunction

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [8:0] st, input string tag);
        int n;
        n = 0;
        while (State !== st && n < 500) begin
            tick;
            n++;
        end
        check(tag, 32'(State), 32'(st));
    endtask

    task automatic press(input logic [3:0] b);
        Btn = b;
        tick;
        Btn = 4'b0000;
        tick;
        tick;
    endtask

    task automatic show_level(input int lvl);
        int n;
        for (int i = 0; i < lvl; i++) begin
            wait_state(S_SHOW_ON, "enter_show_on");
            check("show_color", 32'(Show_color), 32'(oh(exp_seq[i])));
            n = 0;
            while (State === S_SHOW_ON && n < 50) begin
                n++;
                tick;
            end
            check("show_len", 32'(n), 32'd4);
            check("gap_dark", 32'(Show_color), 32'd0);
            n = 0;
            while (State === S_SHOW_OFF && n < 50) begin
                n++;
                tick;
            end
            check("gap_len", 32'(n), 32'd4);
        end
        check("wait_in_state", 32'(State), 32'(S_WAIT_IN));
        check("wait_in_level", 32'(Level), 32'(lvl));
        check("wait_in_score", 32'(Score), 32'(lvl * (lvl - 1) / 2));
    endtask

    task automatic enter_level(input int lvl);
        for (int i = 0; i < lvl; i++) begin
            press(oh(exp_seq[i]));
        end
    endtask

    task automatic start_from_idle;
        Start = 1'b1;
        tick;
        check("start_gen", 32'(State), 32'(S_GEN));
        check("start_level", 32'(Level), 32'd1);
        check("start_score", 32'(Score), 32'd0);
        Start = 1'b0;
    endtask

    task automatic restart_from_end;
        Start = 1'b1;
        tick;
        check("restart_idle", 32'(State), 32'(S_IDLE));
        tick;
        check("restart_gen", 32'(State), 32'(S_GEN));
        Start = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b0;
        Start   = 1'b0;
        On      = 1'b1;
        Seed    = 16'h0001;
        Btn     = 4'b0000;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_state", 32'(State), 32'(S_IDLE));
        check("rst_level", 32'(Level), 32'd0);
        check("rst_score", 32'(Score), 32'd0);
        check("rst_show", 32'(Show_color), 32'd0);
        Reset_n = 1'b1;
        tick;
        tick;
        check("idle_hold", 32'(State), 32'(S_IDLE));

        // Seed 1: LFSR values 0001,0002,0004,0008 -> colours 1,2,0,0
        exp_seq = '{1, 2, 0, 0};
        start_from_idle;
        for (int l = 1; l <= 4; l++) begin
            show_level(l);
            enter_level(l);
        end
        check("win_state", 32'(State), 32'(S_WIN));
        check("win_level", 32'(Level), 32'd4);
        check("win_score", 32'(Score), 32'd10);
        repeat (3) tick;
        check("win_hold", 32'(State), 32'(S_WIN));

        // Wrong colour on third entry of level 3
        restart_from_end;
        for (int l = 1; l <= 2; l++) begin
            show_level(l);
            enter_level(l);
        end
        show_level(3);
        press(oh(1));
        press(oh(2));
        check("pre_wrong_state", 32'(State), 32'(S_WAIT_IN));
        press(oh(3));
        check("wrong_lost", 32'(State), 32'(S_LOST));
        check("wrong_level", 32'(Level), 32'd3);
        check("wrong_score", 32'(Score), 32'd3);
        check("wrong_show", 32'(Show_color), 32'd0);
        repeat (2) tick;
        check("lost_hold_score", 32'(Score), 32'd3);

        // Held button ignored, then two buttons together lose
        restart_from_end;
        wait_state(S_SHOW_OFF, "held_wait_off");
        Btn = 4'b0010;
        wait_state(S_WAIT_IN, "held_wait_in");
        repeat (3) tick;
        check("held_ignored", 32'(State), 32'(S_WAIT_IN));
        Btn = 4'b0000;
        tick;
        check("released_wait", 32'(State), 32'(S_WAIT_IN));
        Btn = 4'b0011;
        tick;
        check("two_btn_lost", 32'(State), 32'(S_LOST));
        Btn = 4'b0000;

        // On dropped during playback
        restart_from_end;
        show_level(1);
        press(oh(1));
        check("single_release", 32'(State), 32'(S_GEN));
        wait_state(S_SHOW_ON, "off_wait_show");
        check("off_pre_show", 32'(Show_color), 32'(oh(1)));
        On = 1'b0;
        tick;
        check("off_idle", 32'(State), 32'(S_IDLE));
        check("off_show", 32'(Show_color), 32'd0);
        check("off_level", 32'(Level), 32'd2);
        check("off_score", 32'(Score), 32'd1);
        On = 1'b1;
        tick;
        check("on_idle_hold", 32'(State), 32'(S_IDLE));

        // Input wait with no press
        start_from_idle;
        show_level(1);
`ifdef SIMON_TIMEOUT_EN
        repeat (19) tick;
        check("tmo_not_yet", 32'(State), 32'(S_WAIT_IN));
        tick;
        check("tmo_lost", 32'(State), 32'(S_LOST));
`else
        repeat (1000) tick;
        check("no_tmo_wait", 32'(State), 32'(S_WAIT_IN));
`endif

        // Seed ACE1 -> LFSR ACE1,59C3 -> colours 1,3
        exp_seq = '{1, 3, 0, 0};
        On = 1'b0;
        tick;
        On   = 1'b1;
        Seed = 16'hACE1;
        start_from_idle;
        show_level(1);
        enter_level(1);
        show_level(2);

        // Seed 0 must give the same sequence
        On = 1'b0;
        tick;
        On   = 1'b1;
        Seed = 16'h0000;
        start_from_idle;
        show_level(1);
        enter_level(1);
        wait_state(S_SHOW_ON, "seed0_show2");
        check("seed0_color2", 32'(Show_color), 32'(oh(1)));
        tick;
        #3;
        Reset_n = 1'b0;
        #1;
        check("async_rst_state", 32'(State), 32'(S_IDLE));
        check("async_rst_level", 32'(Level), 32'd0);
        check("async_rst_score", 32'(Score), 32'd0);
        check("async_rst_show", 32'(Show_color), 32'd0);
        Reset_n = 1'b1;
        tick;
        tick;
        check("post_rst_idle", 32'(State), 32'(S_IDLE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/simon_game_engine.md
SIMON_GAME_ENGINE -- requirements
Module: simon_game_engine

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NUM_COLORS, 4, number of colours/buttons; legal range 2..8.
  MAX_LEN, 16, longest sequence (winning level); legal range 1..64.
  SHOW_CYCLES, 50_000_000, cycles a colour stays lit during playback.
  GAP_CYCLES, 25_000_000, dark cycles between lit colours.
  TIMEOUT_CYCLES, 500_000_000, input wait limit when the timeout feature is compiled in.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  Clk, in, 1, single clock; all logic on its rising edge.
  Reset_n, in, 1, asynchronous active-low reset.
  Start, in, 1, begin or restart a game.
  On, in, 1, game enable (SW0); low forces exit.
  Seed, in, 16, LFSR seed captured at game start.
  Btn, in, NUM_COLORS, user buttons; bit k = colour k.
  Show_color, out, NUM_COLORS, one-hot lit colour during playback; 0 otherwise.
  Level, out, 7, current sequence length.
  Score, out, 16, accumulated score.
  State, out, 9, one-hot state {WIN,LOST,CHECK,RELEASE,WAIT_IN,SHOW_OFF,SHOW_ON,GEN,IDLE}.

Function
REQ-003 The FSM SHALL use states IDLE, GEN, SHOW_ON, SHOW_OFF, WAIT_IN, RELEASE, CHECK, LOST and WIN, encoded one-hot.
REQ-004 In IDLE with Start=1 and On=1, the block SHALL load the LFSR from Seed (16'hACE1 if Seed==0), set Level=1 and Score=0, and go to GEN.
REQ-005 GEN SHALL last 1 cycle: write colour (LFSR mod NUM_COLORS) to sequence entry Level-1, step the LFSR once, clear idx, and go to SHOW_ON.
REQ-006 Earlier sequence entries SHALL be preserved; each level appends exactly one colour.
REQ-007 SHOW_ON SHALL drive Show_color=onehot(seq[idx]) for exactly SHOW_CYCLES cycles, then go to SHOW_OFF (Show_color=0) for GAP_CYCLES cycles.
REQ-008 After SHOW_OFF, if idx<Level-1 the block SHALL increment idx and return to SHOW_ON; otherwise it SHALL clear idx and go to WAIT_IN.
REQ-009 In WAIT_IN, a press SHALL be a cycle where Btn!=0 and the previous-cycle Btn==0; buttons held on entry SHALL be ignored until released.
REQ-010 A press with exactly one bit set SHALL be captured and move to RELEASE; a press with two or more bits set SHALL go directly to LOST.
REQ-011 RELEASE SHALL wait until Btn==0, then go to CHECK.
REQ-012 CHECK SHALL last 1 cycle. On a mismatch it SHALL go to LOST. On a match with idx<Level-1 it SHALL increment idx and go to WAIT_IN.
REQ-013 On a match with idx==Level-1, CHECK SHALL set Score+=Level (saturating at 16'hFFFF), then go to WIN if Level==MAX_LEN, else set Level+=1 and go to GEN.
REQ-014 LOST and WIN SHALL hold Level and Score. Start=1 with On=1 SHALL go to IDLE; a still-high Start then restarts the game on the next cycle.
REQ-015 On=0 in any state SHALL force IDLE on the next edge with Show_color=0, overriding every other transition; Level and Score SHALL be held.
REQ-016 Playback and timeout counters SHALL be cleared on every state entry.

Reset
REQ-017 While Reset_n=0, the block SHALL set: State=IDLE, Level=0, Score=0, Show_color=0, idx=0, counters=0, LFSR=16'hACE1. Sequence memory contents need not be reset.
REQ-018 Reset asserted mid-game SHALL abort immediately with no pending writes; after deassertion the block SHALL wait in IDLE for Start.

Configuration
REQ-019 Macro SIMON_TIMEOUT_EN: when defined, WAIT_IN and RELEASE SHALL count cycles, and reaching TIMEOUT_CYCLES SHALL go to LOST.
REQ-020 When SIMON_TIMEOUT_EN is undefined, WAIT_IN and RELEASE SHALL wait indefinitely, and no timeout counter SHALL be synthesised.

Structure
REQ-021 Package simon_pkg SHALL hold the state one-hot constants, the LFSR default seed 16'hACE1, and the LFSR tap mask (x^16+x^14+x^13+x^11+1).
REQ-022 The Fibonacci LFSR SHALL be a sub-module simon_lfsr with ports Clk, Reset_n, load, seed, step and value[15:0].
REQ-023 Sequence storage SHALL be a MAX_LEN x clog2(NUM_COLORS) register array inside simon_game_engine.

Verification
REQ-024 Scenario: reset, Seed=16'h0001, Start, correct replay of every level through MAX_LEN=4 (SHOW/GAP=4 cycles) -> WIN, Level=4, Score=10.
REQ-025 Scenario: level 3, wrong colour on entry 2 -> LOST; Level=3 and Score=3 held; Show_color=0.
REQ-026 Scenario: two buttons rising together in WAIT_IN -> LOST on the next edge.
REQ-027 Scenario: On dropped during SHOW_ON -> IDLE next edge, Show_color=0; Level and Score unchanged.
REQ-028 Scenario: with SIMON_TIMEOUT_EN and TIMEOUT_CYCLES=20, no press -> LOST exactly 20 cycles after entering WAIT_IN; without the macro, State stays WAIT_IN after 1000 cycles.
REQ-029 Scenario: Seed=0 at Start -> same sequence as Seed=16'hACE1; Reset_n pulsed mid-playback -> all outputs at reset values asynchronously.
